// File: rtl/read_channel_native_pkg.sv
// Shared definitions for the native read channel (cache line-fill engine):
// fill FSM state encoding and the line geometry helpers used to derive
// the word-counter width from the frontend/backend data widths.
package read_channel_native_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HANDSHAKE = 2'd1,
    END       = 2'd2
  } fill_state_t;

  // Number of address bits needed to select a backend word within a line.
  function automatic int line2mem_width(input int word_off_w,
                                        input int be_data_w,
                                        input int fe_data_w);
    return word_off_w - $clog2(be_data_w / fe_data_w);
  endfunction

  // Counter width, kept at least one bit wide even for single-beat lines.
  function automatic int cnt_width(input int line2mem_w);
    return (line2mem_w > 0) ? line2mem_w : 1;
  endfunction

  // Byte-offset bits of one backend word.
  function automatic int byte_width(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/read_channel_native_counter.sv
// Word counter for a line fill: cleared when a fill starts, stepped on every
// accepted backend beat, and flags the last word of the line. A single-beat
// line (LINE2MEM_W == 0) has no counter; the count is tied to zero and every
// beat is the last one.
module read_channel_native_counter
  import read_channel_native_pkg::*;
#(
  parameter int CNT_W      = 3,
  parameter int LINE2MEM_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             incr,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  generate
    if (LINE2MEM_W > 0) begin : g_count
      // Count beats within the line; wraps to zero after the last word.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (incr) begin
          count <= count + CNT_W'(1);
        end
      end
      assign last = &count;
    end else begin : g_single
      assign count = '0;
      assign last  = 1'b1;
    end
  endgenerate

endmodule

// File: rtl/read_channel_native.sv
// Cache line-fill engine for the native backend interface. On a replacement
// request it reads 2**LINE2MEM_W consecutive backend words and streams each
// one, with its offset inside the line, into the cache data memory. A one
// cycle END state follows the last beat so the controller sees the final
// word written before it updates tag/valid.
// Optional feature macro: IOB_CACHE_READ_ADDR_REG_EN registers the line
// address at request time; without it replace_addr must stay stable while
// replace is high.
module read_channel_native
  import read_channel_native_pkg::*;
#(
  parameter int FE_ADDR_W  = 32,
  parameter int FE_DATA_W  = 32,
  parameter int BE_ADDR_W  = FE_ADDR_W,
  parameter int BE_DATA_W  = FE_DATA_W,
  parameter int WORD_OFF_W = 3,
  localparam int BE_BYTE_W  = byte_width(BE_DATA_W),
  localparam int LINE2MEM_W = line2mem_width(WORD_OFF_W, BE_DATA_W, FE_DATA_W),
  localparam int CNT_W      = cnt_width(LINE2MEM_W),
  localparam int LINE_W     = FE_ADDR_W - BE_BYTE_W - LINE2MEM_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 replace_valid,
  input  logic [LINE_W-1:0]    replace_addr,
  output logic                 replace,
  output logic                 read_valid,
  output logic [CNT_W-1:0]     read_addr,
  output logic [BE_DATA_W-1:0] read_data,
  output logic                 mem_valid,
  output logic [BE_ADDR_W-1:0] mem_addr,
  input  logic                 mem_ready,
  input  logic [BE_DATA_W-1:0] mem_rdata
);

  fill_state_t          state_q;
  fill_state_t          state_d;
  logic                 cnt_clear;
  logic                 cnt_incr;
  logic                 cnt_last;
  logic [CNT_W-1:0]     word_counter;
  logic [LINE_W-1:0]    line_addr;
  logic [FE_ADDR_W-1:0] fe_addr;

  read_channel_native_counter #(
    .CNT_W      (CNT_W),
    .LINE2MEM_W (LINE2MEM_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .incr  (cnt_incr),
    .count (word_counter),
    .last  (cnt_last)
  );

  // Fill state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; requests are ignored while busy.
  always_comb begin
    state_d    = state_q;
    replace    = 1'b0;
    mem_valid  = 1'b0;
    read_valid = 1'b0;
    cnt_clear  = 1'b0;
    cnt_incr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (replace_valid) begin
          state_d   = HANDSHAKE;
          cnt_clear = 1'b1;
        end
      end
      HANDSHAKE: begin
        replace   = 1'b1;
        mem_valid = 1'b1;
        if (mem_ready) begin
          read_valid = 1'b1;
          cnt_incr   = 1'b1;
          if (cnt_last) begin
            state_d = END;
          end
        end
      end
      END: begin
        replace = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef IOB_CACHE_READ_ADDR_REG_EN
  logic [LINE_W-1:0] line_addr_q;

  // Hold the line address from the accepted request for the whole fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_addr_q <= '0;
    end else if ((state_q == IDLE) && replace_valid) begin
      line_addr_q <= replace_addr;
    end
  end

  assign line_addr = line_addr_q;
`else
  assign line_addr = replace_addr;
`endif

  generate
    if (LINE2MEM_W > 0) begin : g_addr_multi
      assign fe_addr = {line_addr, word_counter[LINE2MEM_W-1:0], {BE_BYTE_W{1'b0}}};
    end else begin : g_addr_single
      assign fe_addr = {line_addr, {BE_BYTE_W{1'b0}}};
    end
  endgenerate

  assign mem_addr  = BE_ADDR_W'(fe_addr);
  assign read_addr = word_counter;
  assign read_data = mem_rdata;

endmodule
